// File: rtl/bomberman_pkg.sv
// Shared constants, ROM bank encodings and blitter state type for the
// bomberman video path.
package bomberman_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int TILE     = 8;
  localparam int FB_AW    = 15;

  localparam logic [1:0] MEM_TITLE  = 2'd0;
  localparam logic [1:0] MEM_STAGE  = 2'd1;
  localparam logic [1:0] MEM_WIN    = 2'd2;
  localparam logic [1:0] MEM_SPRITE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } blit_state_t;

endpackage

// File: rtl/blit_addr_gen.sv
// Pixel scan counters for the blitter: px fastest then py, last-pixel detect,
// ROM / frame-buffer address arithmetic and the off-screen clip flag.
module blit_addr_gen #(
  parameter int SCREEN_W = bomberman_pkg::SCREEN_W,
  parameter int SCREEN_H = bomberman_pkg::SCREEN_H,
  parameter int TILE     = bomberman_pkg::TILE
) (
  input  logic                           clock,
  input  logic                           resetn,
  input  logic                           i_clear,
  input  logic                           i_step,
  input  logic                           i_tile,
  input  logic [3:0]                     i_sprite_id,
  input  logic [7:0]                     i_tile_x,
  input  logic [6:0]                     i_tile_y,
  output logic [bomberman_pkg::FB_AW-1:0] o_rom_addr,
  output logic [bomberman_pkg::FB_AW-1:0] o_fb_addr,
  output logic                           o_clip,
  output logic                           o_last
);
  import bomberman_pkg::*;

  logic [7:0]       r_px;
  logic [6:0]       r_py;
  logic [7:0]       w_xmax;
  logic [6:0]       w_ymax;
  logic [FB_AW-1:0] w_px;
  logic [FB_AW-1:0] w_py;
  logic [FB_AW-1:0] w_dst_x;
  logic [FB_AW-1:0] w_dst_y;
  logic [FB_AW-1:0] w_lin;

  assign w_xmax = i_tile ? 8'(TILE - 1) : 8'(SCREEN_W - 1);
  assign w_ymax = i_tile ? 7'(TILE - 1) : 7'(SCREEN_H - 1);
  assign o_last = (r_px == w_xmax) && (r_py == w_ymax);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_px <= '0;
      r_py <= '0;
    end else if (i_clear) begin
      r_px <= '0;
      r_py <= '0;
    end else if (i_step) begin
      if (r_px == w_xmax) begin
        r_px <= '0;
        r_py <= (r_py == w_ymax) ? '0 : r_py + 7'd1;
      end else begin
        r_px <= r_px + 8'd1;
      end
    end
  end

  assign w_px    = FB_AW'(r_px);
  assign w_py    = FB_AW'(r_py);
  assign w_dst_x = FB_AW'(i_tile_x) + w_px;
  assign w_dst_y = FB_AW'(i_tile_y) + w_py;
  assign w_lin   = w_py * FB_AW'(SCREEN_W) + w_px;

  // Clipped pixels are still scanned so tile latency never depends on position.
  assign o_clip = i_tile && ((w_dst_x >= FB_AW'(SCREEN_W)) || (w_dst_y >= FB_AW'(SCREEN_H)));

  always_comb begin
    o_rom_addr = w_lin;
    o_fb_addr  = w_lin;
    if (i_tile) begin
      o_rom_addr = FB_AW'(i_sprite_id) * FB_AW'(TILE * TILE) + w_py * FB_AW'(TILE) + w_px;
      o_fb_addr  = w_dst_y * FB_AW'(SCREEN_W) + w_dst_x;
    end
  end

endmodule

// File: rtl/bomberman_blitter.sv
// Pixel copy engine: full-frame or single-tile ROM to frame-buffer blits.
// Define BLIT_TRANSPARENCY_EN to skip sprite pixels matching KEY_COLOUR.
module bomberman_blitter #(
  parameter int         SCREEN_W   = bomberman_pkg::SCREEN_W,
  parameter int         SCREEN_H   = bomberman_pkg::SCREEN_H,
  parameter int         TILE       = bomberman_pkg::TILE,
  parameter logic [2:0] KEY_COLOUR = 3'b000
) (
  input  logic                           clock,
  input  logic                           resetn,
  input  logic                           start,
  input  logic [1:0]                     memory_select,
  input  logic                           black,
  input  logic [7:0]                     tile_x,
  input  logic [6:0]                     tile_y,
  input  logic [3:0]                     sprite_id,
  input  logic [2:0]                     rom_data,
  output logic [1:0]                     rom_sel,
  output logic [bomberman_pkg::FB_AW-1:0] rom_addr,
  output logic [bomberman_pkg::FB_AW-1:0] fb_addr,
  output logic [2:0]                     fb_data,
  output logic                           fb_we,
  output logic                           busy,
  output logic                           finished
);
  import bomberman_pkg::*;

  blit_state_t      r_state;
  blit_state_t      w_next;
  logic             w_latch;
  logic             w_step;
  logic             w_last;
  logic             w_clip;
  logic             w_tile;
  logic             w_transparent;
  logic [FB_AW-1:0] w_rom_addr;
  logic [FB_AW-1:0] w_fb_addr;

  logic [1:0]       r_mem_sel;
  logic             r_black;
  logic [7:0]       r_tile_x;
  logic [6:0]       r_tile_y;
  logic [3:0]       r_sprite_id;
  logic             r_pipe_valid;
  logic             r_pipe_clip;
  logic [FB_AW-1:0] r_pipe_addr;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_RUN;
      ST_RUN:   if (w_last) w_next = ST_DRAIN;
      ST_DRAIN: w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_latch  = (r_state == ST_IDLE) && start;
    w_step   = (r_state == ST_RUN);
    busy     = (r_state != ST_IDLE);
    finished = (r_state == ST_DONE);
  end

  // Request fields are frozen for the whole blit; the controller may change them freely.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_mem_sel   <= '0;
      r_black     <= 1'b0;
      r_tile_x    <= '0;
      r_tile_y    <= '0;
      r_sprite_id <= '0;
    end else if (w_latch) begin
      r_mem_sel   <= memory_select;
      r_black     <= black;
      r_tile_x    <= tile_x;
      r_tile_y    <= tile_y;
      r_sprite_id <= sprite_id;
    end
  end

  assign w_tile  = (r_mem_sel == MEM_SPRITE);
  assign rom_sel = r_mem_sel;

  blit_addr_gen #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H),
    .TILE     (TILE)
  ) u_addr_gen (
    .clock       (clock),
    .resetn      (resetn),
    .i_clear     (w_latch),
    .i_step      (w_step),
    .i_tile      (w_tile),
    .i_sprite_id (r_sprite_id),
    .i_tile_x    (r_tile_x),
    .i_tile_y    (r_tile_y),
    .o_rom_addr  (w_rom_addr),
    .o_fb_addr   (w_fb_addr),
    .o_clip      (w_clip),
    .o_last      (w_last)
  );

  assign rom_addr = w_step ? w_rom_addr : '0;

  // One-stage write pipeline lines the frame-buffer address up with rom_data.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_pipe_valid <= 1'b0;
      r_pipe_clip  <= 1'b0;
      r_pipe_addr  <= '0;
    end else begin
      r_pipe_valid <= w_step;
      r_pipe_clip  <= w_step && w_clip;
      r_pipe_addr  <= w_step ? w_fb_addr : '0;
    end
  end

`ifdef BLIT_TRANSPARENCY_EN
  assign w_transparent = w_tile && !r_black && (rom_data == KEY_COLOUR);
`else
  assign w_transparent = 1'b0;
`endif

  assign fb_addr = r_pipe_addr;
  assign fb_data = (r_pipe_valid && !(w_tile && r_black)) ? rom_data : 3'b000;
  assign fb_we   = r_pipe_valid && !r_pipe_clip && !w_transparent;

endmodule

// File: tb/tb_bomberman_blitter.sv
// Randomized self-checking bench for bomberman_blitter against a pixel-list
// reference model built directly from the blit rules.
module tb_bomberman_blitter;

  logic        clock = 1'b0;
  logic        resetn;
  logic        start;
  logic [1:0]  memory_select;
  logic        black;
  logic [7:0]  tile_x;
  logic [6:0]  tile_y;
  logic [3:0]  sprite_id;
  logic [2:0]  rom_data;
  logic [1:0]  rom_sel;
  logic [14:0] rom_addr;
  logic [14:0] fb_addr;
  logic [2:0]  fb_data;
  logic        fb_we;
  logic        busy;
  logic        finished;

  int  checkCount = 0;
  int  failCount  = 0;
  int  romConst   = -1;
  int  romSalt    = 0;
  time lastFinTime = 0;

  always #5 clock = ~clock;

  bomberman_blitter dut (
    .clock         (clock),
    .resetn        (resetn),
    .start         (start),
    .memory_select (memory_select),
    .black         (black),
    .tile_x        (tile_x),
    .tile_y        (tile_y),
    .sprite_id     (sprite_id),
    .rom_data      (rom_data),
    .rom_sel       (rom_sel),
    .rom_addr      (rom_addr),
    .fb_addr       (fb_addr),
    .fb_data       (fb_data),
    .fb_we         (fb_we),
    .busy          (busy),
    .finished      (finished)
  );

  // ROM contents: a fixed hash of bank and address, or a constant colour.
  function automatic logic [2:0] romVal(input int sel, input int addr);
    int v;
    v = (addr * 5) ^ (addr >> 4) ^ (sel * 3) ^ romSalt;
    if (romConst >= 0) v = romConst;
    return v[2:0];
  endfunction

  // Synchronous ROM: data valid one cycle after the address.
  always @(posedge clock) rom_data <= romVal(int'(rom_sel), int'(rom_addr));

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic idleCheck(input string tag, input int cycles);
    repeat (cycles) begin
      @(negedge clock);
      checkOutput({tag, "_busy"}, int'(busy), 0);
      checkOutput({tag, "_we"}, int'(fb_we), 0);
    end
  endtask

  // Applies one draw request and checks every write, its cycle and the finish pulse.
  // gap = rising edges until the latching edge; abortAt > 0 drops reset at that cycle.
  task automatic applyStimulus(input int sel, input int blk, input int tx, input int ty,
                               input int sid, input bit holdStart, input int gap,
                               input int abortAt, input string tag);
    int  expA[$];
    int  expD[$];
    int  expC[$];
    int  n, c, wrIdx, finCyc, firstRom;
    bit  tile, bad, errNow;

    tile     = (sel == 3);
    n        = tile ? 64 : 19200;
    firstRom = tile ? sid * 64 : 0;

    if (tile) begin
      for (int py = 0; py < 8; py++) begin
        for (int px = 0; px < 8; px++) begin
          int x, y, d;
          bit skip;
          x = tx + px;
          y = ty + py;
          d = (blk != 0) ? 0 : int'(romVal(sel, sid * 64 + py * 8 + px));
          skip = (x >= 160) || (y >= 120);
`ifdef BLIT_TRANSPARENCY_EN
          if (blk == 0 && d == 0) skip = 1'b1;
`endif
          if (!skip) begin
            expA.push_back(y * 160 + x);
            expD.push_back(d);
            expC.push_back(2 + py * 8 + px);
          end
        end
      end
    end else begin
      for (int i = 0; i < 19200; i++) begin
        expA.push_back(i);
        expD.push_back(int'(romVal(sel, i)));
        expC.push_back(2 + i);
      end
    end

    memory_select = 2'(sel);
    black         = 1'(blk);
    tile_x        = 8'(tx);
    tile_y        = 7'(ty);
    sprite_id     = 4'(sid);
    start         = 1'b1;
    if (gap == 1) checkOutput({tag, "_idle_busy"}, int'(busy), 0);
    repeat (gap) @(posedge clock);
    @(negedge clock);
    if (!holdStart) start = 1'b0;

    c = 1; wrIdx = 0; finCyc = -1; bad = 1'b0;
    forever begin
      if (c == abortAt) begin
        resetn = 1'b0;
        #1;
        checkOutput({tag, "_rst_busy"}, int'(busy), 0);
        checkOutput({tag, "_rst_we"}, int'(fb_we), 0);
        checkOutput({tag, "_rst_fin"}, int'(finished), 0);
        checkOutput({tag, "_rst_rom_addr"}, int'(rom_addr), 0);
        checkOutput({tag, "_rst_fb_addr"}, int'(fb_addr), 0);
        checkOutput({tag, "_rst_fb_data"}, int'(fb_data), 0);
        checkOutput({tag, "_rst_rom_sel"}, int'(rom_sel), 0);
        repeat (4) begin
          @(negedge clock);
          checkOutput({tag, "_rst_hold_fin"}, int'(finished), 0);
        end
        resetn = 1'b1;
        @(negedge clock);
        return;
      end
      if (c == 1) begin
        checkOutput({tag, "_busy_c1"}, int'(busy), 1);
        checkOutput({tag, "_rom_addr_c1"}, int'(rom_addr), firstRom);
        checkOutput({tag, "_rom_sel"}, int'(rom_sel), sel);
      end
      if (fb_we === 1'b1) begin
        if (!bad) begin
          if (wrIdx >= expA.size()) begin
            checkOutput({tag, "_unexpected_write_addr"}, int'(fb_addr), -1);
            bad = 1'b1;
          end else begin
            errNow = (int'(fb_addr) != expA[wrIdx]) || (int'(fb_data) != expD[wrIdx]) ||
                     (c != expC[wrIdx]);
            checkOutput($sformatf("%s_w%0d_addr", tag, wrIdx), int'(fb_addr), expA[wrIdx]);
            checkOutput($sformatf("%s_w%0d_data", tag, wrIdx), int'(fb_data), expD[wrIdx]);
            checkOutput($sformatf("%s_w%0d_cycle", tag, wrIdx), c, expC[wrIdx]);
            if (errNow) bad = 1'b1;
          end
        end
        wrIdx++;
      end
      if (finished === 1'b1) begin
        finCyc = c;
        lastFinTime = $time;
        checkOutput({tag, "_busy_done"}, int'(busy), 1);
        break;
      end
      if (c >= n + 10) break;
      @(negedge clock);
      c++;
    end

    checkOutput({tag, "_finish_cycle"}, finCyc, n + 2);
    checkOutput({tag, "_write_count"}, wrIdx, expA.size());
    if (!holdStart) begin
      @(negedge clock);
      checkOutput({tag, "_busy_end"}, int'(busy), 0);
    end
  endtask

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    time t1;
    int  sel2;
    resetn = 1'b0; start = 1'b0; memory_select = '0; black = 1'b0;
    tile_x = '0; tile_y = '0; sprite_id = '0;
    #1;
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_finished", int'(finished), 0);
    checkOutput("reset_we", int'(fb_we), 0);
    checkOutput("reset_rom_addr", int'(rom_addr), 0);
    checkOutput("reset_fb_addr", int'(fb_addr), 0);
    checkOutput("reset_rom_sel", int'(rom_sel), 0);
    checkOutput("reset_fb_data", int'(fb_data), 0);
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);

    romSalt = int'($urandom_range(0, 7));
    applyStimulus(1, 0, 0, 0, 0, 1'b0, 1, -1, "full_stage");
    idleCheck("full_stage_after", 4);
    sel2 = ($urandom_range(0, 1) == 0) ? 0 : 2;
    applyStimulus(sel2, 0, 0, 0, 0, 1'b0, 1, -1, "full_rand");

    applyStimulus(3, 0, 16, 8, 3, 1'b0, 1, -1, "tile_16_8");
    applyStimulus(3, 0, 156, 116, 1, 1'b0, 1, -1, "tile_clip");

    romConst = 5;
    applyStimulus(3, 1, 40, 30, 7, 1'b0, 1, -1, "tile_black");
    romConst = 0;
    applyStimulus(3, 0, 48, 20, 2, 1'b0, 1, -1, "tile_key");
    romConst = -1;

    applyStimulus(3, 0, 10, 10, 3, 1'b1, 1, -1, "b2b_first");
    t1 = lastFinTime;
    applyStimulus(3, 0, 10, 10, 5, 1'b0, 2, -1, "b2b_second");
    checkOutput("b2b_gap", int'((lastFinTime - t1) / 10), 67);

    applyStimulus(3, 0, 20, 20, 2, 1'b0, 1, 30, "tile_reset");
    applyStimulus(3, 0, 20, 20, 2, 1'b0, 1, -1, "tile_after_reset");

    for (int k = 0; k < 6; k++) begin
      romSalt = int'($urandom_range(0, 7));
      applyStimulus(3, ($urandom_range(0, 3) == 0) ? 1 : 0, int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 127)), int'($urandom_range(0, 15)),
                    1'b0, 1, -1, $sformatf("tile_rand%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
